// File: rtl/usbh_hid_report_arbiter.sv
// Round-robin merge of one-report-deep HID buffers from several USB host ports into one tagged stream.
// Latency: strobe at edge N reaches out_valid after edge N+1 when idle; back-to-back grants follow on every accepting cycle.
// Backpressure: out_valid/out_report hold until out_ready; a port re-strobing while pending overwrites it and pulses overrun.
// Optional feature: define HID_ARB_STALE_EN for per-port stale timeout (port_active drop, buffer cleared).
module usbh_hid_report_arbiter #(
  parameter int C_ports        = 3,
  parameter int C_report_bytes = 20,
  parameter int C_stale_cycles = 6000000
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [C_ports*C_report_bytes*8-1:0] hid_report,
  input  logic [C_ports-1:0]                hid_valid,
  output logic [C_report_bytes*8-1:0]       out_report,
  output logic [1:0]                        out_port,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [C_ports-1:0]                port_active,
  output logic                              overrun
);

  localparam int RW = C_report_bytes * 8;
  localparam int PW = (C_ports > 1) ? $clog2(C_ports) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [RW-1:0]   hold [C_ports];
  logic [C_ports-1:0] pending;
  logic [PW-1:0]   rr;
  logic            hi_any;
  logic            lo_any;
  logic [PW-1:0]   hi_idx;
  logic [PW-1:0]   lo_idx;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            grant_fire;
  logic            out_clear;
  logic [C_ports-1:0] gnt_mask;
  logic [C_ports-1:0] stale_hit;

  // Out-of-range configurations leave this named block in the hierarchy as a marker.
  if (C_ports < 1 || C_ports > 4 || C_stale_cycles < 1) begin : g_cfg_invalid
  end

`ifdef HID_ARB_STALE_EN
  localparam int CW = $clog2(C_stale_cycles + 1);
  localparam logic [CW-1:0] STALE_MAX  = CW'(C_stale_cycles);
  localparam logic [CW-1:0] STALE_LAST = CW'(C_stale_cycles - 1);

  logic [CW-1:0] stale_cnt [C_ports];

  // Per-port idle counter: restarts on every report, parks at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < C_ports; i++) stale_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < C_ports; i++) begin
        if (hid_valid[i])                 stale_cnt[i] <= '0;
        else if (stale_cnt[i] != STALE_MAX) stale_cnt[i] <= stale_cnt[i] + CW'(1);
      end
    end
  end

  // Single-cycle stale event on the transition into the limit; a fresh report suppresses it.
  always_comb begin
    stale_hit = '0;
    for (int i = 0; i < C_ports; i++)
      stale_hit[i] = !hid_valid[i] && (stale_cnt[i] == STALE_LAST);
  end
`else
  assign stale_hit = '0;
`endif

  // Round-robin pick: lowest pending index at/after rr, otherwise lowest pending overall (wrap).
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = C_ports - 1; i >= 0; i--) begin
      if (pending[i]) begin
        if (i >= int'(rr)) begin
          hi_any = 1'b1;
          hi_idx = PW'(i);
        end
        lo_any = 1'b1;
        lo_idx = PW'(i);
      end
    end
    gnt_any = lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  // FSM next state and grant/drop decisions.
  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    out_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_any) begin
          grant_fire = 1'b1;
          state_nxt  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (gnt_any) begin
            grant_fire = 1'b1;
          end else begin
            out_clear = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One-hot of the port being granted this cycle (used to exempt it from overrun).
  always_comb begin
    gnt_mask = '0;
    for (int i = 0; i < C_ports; i++)
      gnt_mask[i] = grant_fire && (gnt_idx == PW'(i));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Per-port buffers: capture beats grant-clear, stale clears everything the port owns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < C_ports; i++) hold[i] <= '0;
      pending     <= '0;
      port_active <= '0;
    end else begin
      for (int i = 0; i < C_ports; i++) begin
        if (hid_valid[i]) begin
          hold[i]        <= hid_report[i*RW +: RW];
          pending[i]     <= 1'b1;
          port_active[i] <= 1'b1;
        end else if (stale_hit[i]) begin
          hold[i]        <= '0;
          pending[i]     <= 1'b0;
          port_active[i] <= 1'b0;
        end else if (gnt_mask[i]) begin
          pending[i]     <= 1'b0;
        end
      end
    end
  end

  // Overrun: a new report lands on a still-pending, not-being-granted buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) overrun <= 1'b0;
    else         overrun <= |(hid_valid & pending & ~gnt_mask);
  end

  // Output register and round-robin pointer; output only changes on a grant or a drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_report <= '0;
      out_port   <= '0;
      out_valid  <= 1'b0;
      rr         <= '0;
    end else if (grant_fire) begin
      out_report <= hold[gnt_idx];
      out_port   <= 2'(gnt_idx);
      out_valid  <= 1'b1;
      rr         <= (gnt_idx == PW'(C_ports - 1)) ? '0 : gnt_idx + PW'(1);
    end else if (out_clear) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usbh_hid_report_arbiter.sv
// Directed self-checking bench for usbh_hid_report_arbiter (3 ports, 20-byte reports, stale limit 100).
module tb_usbh_hid_report_arbiter;

  localparam int NP = 3;
  localparam int NB = 20;
  localparam int RW = NB * 8;

  logic              clk;
  logic              resetn;
  logic [NP*RW-1:0]  hid_report;
  logic [NP-1:0]     hid_valid;
  logic [RW-1:0]     out_report;
  logic [1:0]        out_port;
  logic              out_valid;
  logic              out_ready;
  logic [NP-1:0]     port_active;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  usbh_hid_report_arbiter #(
    .C_ports(NP), .C_report_bytes(NB), .C_stale_cycles(100)
  ) dut (
    .clk(clk), .resetn(resetn), .hid_report(hid_report), .hid_valid(hid_valid),
    .out_report(out_report), .out_port(out_port), .out_valid(out_valid),
    .out_ready(out_ready), .port_active(port_active), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] pat(input logic [7:0] b);
    return {NB{b}};
  endfunction

  // Advance one rising edge, then settle 1 time unit for driving and sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_report(input int port, input logic [7:0] b);
    hid_report[port*RW +: RW] = pat(b);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    hid_valid = '0;
    out_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    hid_report = '0;
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_port !== 2'd0) begin errors++; $display("FAIL reset_out_port got %0d want 0", out_port); end
    checks++; if (out_report !== '0) begin errors++; $display("FAIL reset_out_report got %h want 0", out_report); end
    checks++; if (port_active !== 3'b000) begin errors++; $display("FAIL reset_port_active got %b want 000", port_active); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_single_port();
    out_ready = 1'b1;
    set_report(0, 8'hA5);
    hid_valid = 3'b001;
    tick();                                   // edge N: captured
    hid_valid = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    tick();                                   // edge N+1: granted
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_port !== 2'd0) begin errors++; $display("FAIL single_port got %0d want 0", out_port); end
    checks++; if (out_report !== pat(8'hA5)) begin errors++; $display("FAIL single_report got %h want %h", out_report, pat(8'hA5)); end
    checks++; if (port_active !== 3'b001) begin errors++; $display("FAIL single_active got %b want 001", port_active); end
    tick();                                   // accepted, nothing pending
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    apply_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) set_report(p, exp_b[p]);
    hid_valid = 3'b111;
    tick();
    hid_valid = '0;
    for (int p = 0; p < 3; p++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_port !== 2'(p)) begin errors++; $display("FAIL simul_grant%0d got valid %b port %0d want valid 1 port %0d", p, out_valid, out_port, p); end
      checks++; if (out_report !== pat(exp_b[p])) begin errors++; $display("FAIL simul_report%0d got %h want %h", p, out_report, pat(exp_b[p])); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_drop got %b want 0", out_valid); end
    checks++; if (port_active !== 3'b111) begin errors++; $display("FAIL simul_active got %b want 111", port_active); end
    set_report(1, 8'h2B);
    hid_valid = 3'b010;
    tick();
    hid_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_port !== 2'd1 || out_report !== pat(8'h2B)) begin errors++; $display("FAIL simul_next_round got valid %b port %0d report %h want 1 1 %h", out_valid, out_port, out_report, pat(8'h2B)); end
    tick();
  endtask

  task automatic test_backpressure();
    int ovr_cnt;
    bit stable_ok;
    out_ready = 1'b0;
    set_report(0, 8'h55);
    hid_valid = 3'b001;
    tick();
    hid_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_port !== 2'd0) begin errors++; $display("FAIL bp_hold got valid %b port %0d want 1 0", out_valid, out_port); end
    ovr_cnt = 0;
    stable_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 2)  begin set_report(1, 8'h66); hid_valid = 3'b010; end
      else if (c == 9) begin set_report(1, 8'h77); hid_valid = 3'b010; end
      else hid_valid = '0;
      tick();
      if (overrun === 1'b1) ovr_cnt++;
      if (out_valid !== 1'b1 || out_port !== 2'd0 || out_report !== pat(8'h55)) stable_ok = 1'b0;
    end
    hid_valid = '0;
    checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL bp_overrun_count got %0d want 1", ovr_cnt); end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", stable_ok); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_port !== 2'd1 || out_report !== pat(8'h77)) begin errors++; $display("FAIL bp_second got valid %b port %0d report %h want 1 1 %h", out_valid, out_port, out_report, pat(8'h77)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", out_valid); end
  endtask

  task automatic test_capture_grant();
    apply_reset();
    out_ready = 1'b1;
    set_report(2, 8'h88);
    hid_valid = 3'b100;
    tick();                                   // pending[2] set
    set_report(2, 8'h99);
    hid_valid = 3'b100;                       // captured on the same edge as the grant
    tick();
    hid_valid = '0;
    checks++; if (out_valid !== 1'b1 || out_port !== 2'd2 || out_report !== pat(8'h88)) begin errors++; $display("FAIL cg_old got valid %b port %0d report %h want 1 2 %h", out_valid, out_port, out_report, pat(8'h88)); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL cg_overrun got %b want 0", overrun); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_port !== 2'd2 || out_report !== pat(8'h99)) begin errors++; $display("FAIL cg_new got valid %b port %0d report %h want 1 2 %h", out_valid, out_port, out_report, pat(8'h99)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cg_drop got %b want 0", out_valid); end
  endtask

  task automatic test_reset_in_hold();
    bit quiet;
    out_ready = 1'b0;
    set_report(1, 8'hAA);
    hid_valid = 3'b010;
    tick();
    hid_valid = '0;
    tick();
    set_report(0, 8'hBB);
    hid_valid = 3'b001;
    tick();
    hid_valid = '0;
    checks++; if (out_valid !== 1'b1 || out_port !== 2'd1) begin errors++; $display("FAIL rh_pre got valid %b port %0d want 1 1", out_valid, out_port); end
    resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_port !== 2'd0 || out_report !== '0 || port_active !== 3'b000 || overrun !== 1'b0) begin errors++; $display("FAIL rh_async got valid %b port %0d report %h active %b ovr %b want all 0", out_valid, out_port, out_report, port_active, overrun); end
    #2;
    resetn = 1'b1;
    out_ready = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rh_no_report got %b want 1", quiet); end
  endtask

  task automatic test_stale();
    apply_reset();
    out_ready = 1'b1;
    set_report(0, 8'hCC);
    hid_valid = 3'b001;
    tick();                                   // edge N
    hid_valid = '0;
    tick();                                   // N+1: delivered
    checks++; if (out_report !== pat(8'hCC) || out_valid !== 1'b1) begin errors++; $display("FAIL stale_deliver got valid %b report %h want 1 %h", out_valid, out_report, pat(8'hCC)); end
    tick();                                   // N+2
    for (int c = 0; c < 97; c++) tick();      // N+99
    checks++; if (port_active[0] !== 1'b1) begin errors++; $display("FAIL stale_before got %b want 1", port_active[0]); end
    tick();                                   // N+100
`ifdef HID_ARB_STALE_EN
    checks++; if (port_active[0] !== 1'b0) begin errors++; $display("FAIL stale_drop got %b want 0", port_active[0]); end
    checks++; if (dut.hold[0] !== '0) begin errors++; $display("FAIL stale_hold got %h want 0", dut.hold[0]); end
`else
    checks++; if (port_active[0] !== 1'b1) begin errors++; $display("FAIL stale_kept got %b want 1", port_active[0]); end
    for (int c = 0; c < 50; c++) tick();
    checks++; if (port_active[0] !== 1'b1) begin errors++; $display("FAIL stale_kept_late got %b want 1", port_active[0]); end
`endif
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_idle got %b want 0", out_valid); end
  endtask

  initial begin
    resetn = 1'b0;
    hid_valid = '0;
    hid_report = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_port();
    test_simultaneous();
    test_backpressure();
    test_capture_grant();
    test_reset_in_hold();
    test_stale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
